// File: rtl/l1_train_pkg.sv
// l1_train_pkg: state encoding, sizing constants and one-hot helper for the L1 training sequencer
package l1_train_pkg;
  localparam int P_N = 4;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {IDLE, COLLECT, DECIDE, LAS_WAIT, TRACE_UPD} state_t;
  function automatic logic [P_N-1:0] lowest_bit(input logic [P_N-1:0] v);
    return v & -v;
  endfunction
endpackage

// File: rtl/rise_det.sv
// rise_det: registered history with combinational rising-edge output per bit
module rise_det #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] prev;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) prev <= '0;
    else prev <= d;
  assign rise = d & ~prev;
endmodule

// File: rtl/l1_train_sequencer.sv
// l1_train_sequencer: single-clock controller issuing collect/decide/LAS strobes for L1 training
module l1_train_sequencer
  import l1_train_pkg::*;
#(
  parameter int P_PASS_CYCLES = 3,
  parameter int P_LAS_TIMEOUT = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [P_N-1:0] i_event,
  input  logic [P_N-1:0] i_spike,
  input  logic           i_gas,
  input  logic           i_las,
  input  logic           i_endof_epochs,
  output logic [P_N-1:0] o_ts_latch,
  output logic [P_N-1:0] o_reward,
  output logic           o_punish_all,
  output logic [P_N-1:0] o_thr_inc,
  output logic           o_tr_latch,
  output logic           o_trace_upd,
  output logic           o_las,
  output logic           o_busy
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [P_N-1:0] winner, ev_rise, sp_rise, nwin;
  logic gas, las_pend, gas_rise, las_rise, ngas;
  rise_det #(.W(P_N)) u_ev  (.i_clk, .i_rst_n, .d(i_event), .rise(ev_rise));
  rise_det #(.W(P_N)) u_sp  (.i_clk, .i_rst_n, .d(i_spike), .rise(sp_rise));
  rise_det #(.W(1))   u_gas (.i_clk, .i_rst_n, .d(i_gas),   .rise(gas_rise));
  rise_det #(.W(1))   u_las (.i_clk, .i_rst_n, .d(i_las),   .rise(las_rise));
  // flags as they will stand after this edge, so decision strobes line up with DECIDE
  assign nwin = winner | sp_rise;
  assign ngas = gas | i_gas;
  assign o_las = |winner;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      winner <= '0;
      gas <= 1'b0;
      las_pend <= 1'b0;
      o_ts_latch <= '0;
      o_reward <= '0;
      o_punish_all <= 1'b0;
      o_thr_inc <= '0;
      o_tr_latch <= 1'b0;
      o_trace_upd <= 1'b0;
    end else begin
      cnt <= '0;
      o_ts_latch <= '0;
      o_reward <= '0;
      o_punish_all <= 1'b0;
      o_thr_inc <= '0;
      o_tr_latch <= 1'b0;
      o_trace_upd <= 1'b0;
      if (i_endof_epochs) begin
        state <= IDLE;
        winner <= '0;
        gas <= 1'b0;
        las_pend <= 1'b0;
      end else
        case (state)
          IDLE:
            if (|ev_rise) begin
              state <= COLLECT;
              winner <= sp_rise;
              gas <= gas_rise;
              las_pend <= 1'b0;
              o_ts_latch <= sp_rise;
            end
          COLLECT: begin
            winner <= nwin;
            gas <= ngas;
            o_ts_latch <= sp_rise;
            if (las_rise) las_pend <= 1'b1;
            if (cnt == CNT_W'(P_PASS_CYCLES - 1)) begin
              state <= DECIDE;
              o_reward <= ngas ? lowest_bit(nwin) : '0;
              o_punish_all <= ngas && nwin == '0;
              o_thr_inc <= (!ngas && nwin == lowest_bit(nwin)) ? nwin : '0;
            end else cnt <= cnt + CNT_W'(1);
          end
          DECIDE: state <= |winner ? LAS_WAIT : IDLE;
          LAS_WAIT:
            if (las_rise || las_pend) begin
              state <= TRACE_UPD;
              las_pend <= 1'b0;
              o_tr_latch <= 1'b1;
            end else if (cnt == CNT_W'(P_LAS_TIMEOUT - 1)) begin
              state <= IDLE;
              winner <= '0;
            end else cnt <= cnt + CNT_W'(1);
          TRACE_UPD: begin
            state <= IDLE;
            winner <= '0;
            o_trace_upd <= 1'b1;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_l1_train_sequencer.sv
// tb_l1_train_sequencer: directed cycle-by-cycle vectors with hand-computed strobe expectations
module tb_l1_train_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] ev = '0, sp = '0;
  logic gas = 1'b0, las = 1'b0, eoe = 1'b0;
  logic [3:0] ts_latch, reward, thr_inc;
  logic punish_all, tr_latch, trace_upd, las_out, busy;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  l1_train_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_event(ev), .i_spike(sp), .i_gas(gas), .i_las(las),
    .i_endof_epochs(eoe), .o_ts_latch(ts_latch), .o_reward(reward), .o_punish_all(punish_all),
    .o_thr_inc(thr_inc), .o_tr_latch(tr_latch), .o_trace_upd(trace_upd), .o_las(las_out), .o_busy(busy)
  );
  wire [16:0] outs = {ts_latch, reward, punish_all, thr_inc, tr_latch, trace_upd, las_out, busy};
  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h {ts,rw,pa,thr,tl,tu,las,busy}", tag, got, exp);
  endtask
  // drive one cycle of inputs, clock once, then compare every output
  task automatic cyc(input string tag, input logic [3:0] e, s, input logic g, l, f,
                     input logic [3:0] ts, rw, input logic pa, input logic [3:0] th,
                     input logic tl, tu, la, bz);
    ev = e; sp = s; gas = g; las = l; eoe = f;
    @(posedge clk); #1;
    chk(tag, outs, {ts, rw, pa, th, tl, tu, la, bz});
  endtask
  initial begin
    #3 chk("reset", outs, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("idle", 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // reward: winner bit 2, gas during collect, then LAS
    cyc("s1c0", 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    cyc("s1c1", 4'b0100, 4'b0100, 0, 0, 0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s1c2", 4'b0100, 4'b0100, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s1c3", 4'b0100, 4'b0100, 1, 0, 0, 4'b0000, 4'b0100, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s1c4", 4'b0100, 4'b0100, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s1c5", 4'b0100, 4'b0100, 1, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 1, 1);
    cyc("s1c6", 4'b0100, 4'b0100, 1, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0, 0);
    cyc("s1c7", 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // punish all: gas, no spike; extra event while busy is dropped
    cyc("s2c0", 4'b0001, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    cyc("s2c1", 4'b0011, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    cyc("s2c2", 4'b0011, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    cyc("s2c3", 4'b0011, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 1);
    cyc("s2c4", 4'b0011, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    cyc("s2c5", 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // two winners, no gas: silent decide, LAS five clocks into the wait
    cyc("s3c0", 4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    cyc("s3c1", 4'b1000, 4'b1001, 0, 0, 0, 4'b1001, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s3c2", 4'b1000, 4'b1001, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s3c3", 4'b1000, 4'b1001, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    for (int k = 4; k <= 8; k++)
      cyc($sformatf("s3c%0d", k), 4'b1000, 4'b1001, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s3c9", 4'b1000, 4'b1001, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 1, 1);
    cyc("s3c10", 4'b1000, 4'b1001, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0, 0);
    cyc("s3c11", 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // single winner bit 1, no gas: threshold raise, then LAS timeout after 16 clocks
    cyc("s4c0", 4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    cyc("s4c1", 4'b0010, 4'b0010, 0, 0, 0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s4c2", 4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s4c3", 4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0010, 0, 0, 1, 1);
    for (int k = 4; k <= 19; k++)
      cyc($sformatf("s4c%0d", k), 4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s4c20", 4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    cyc("s4c21", 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // LAS during collect is remembered and consumed on the first wait clock
    cyc("s5c0", 4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    cyc("s5c1", 4'b0001, 4'b0001, 0, 1, 0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s5c2", 4'b0001, 4'b0001, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s5c3", 4'b0001, 4'b0001, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 1, 1);
    cyc("s5c4", 4'b0001, 4'b0001, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s5c5", 4'b0001, 4'b0001, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 1, 1);
    cyc("s5c6", 4'b0001, 4'b0001, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0, 0);
    cyc("s5c7", 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // training freeze mid-collect, then an event while frozen
    cyc("s6c0", 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    cyc("s6c1", 4'b0100, 4'b0100, 0, 0, 0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    cyc("s6c2", 4'b0100, 4'b0100, 1, 0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    cyc("s6c3", 4'b0100, 4'b0100, 1, 0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    cyc("s6c4", 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    cyc("s6c5", 4'b1000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    cyc("s6c6", 4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    cyc("s6c7", 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    // asynchronous reset in the middle of a collect window
    cyc("s7c0", 4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    cyc("s7c1", 4'b0001, 4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1 chk("s7rst", outs, '0);
    ev = '0; sp = '0; gas = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++)
      cyc($sformatf("s7post%0d", k), 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
